// File: rtl/debounce_pkg.sv
// Shared state encoding and default timing constants for the switch debouncer.
package debounce_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOW       = 2'd0;
  localparam state_t ST_WAIT_HIGH = 2'd1;
  localparam state_t ST_HIGH      = 2'd2;
  localparam state_t ST_WAIT_LOW  = 2'd3;

  localparam int unsigned DEF_STABLE_CNT = 10;
  localparam int unsigned DEF_CNT_W      = 4;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter and level FSM
// producing a registered clean level and a one-cycle rising-edge pulse.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
    end
  end

  // The FSM sees only the synchronized level; any abort or completion clears the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        out_d = 1'b0;
        if (sync2_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        out_d = 1'b0;
        if (!sync2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        out_d = 1'b1;
        if (!sync2_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT_LOW: begin
        out_d = 1'b1;
        if (sync2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          out_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        out_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign out  = out_q;
  assign rise = rise_q;

endmodule

// File: rtl/debounce_3ch.sv
// Three independent debounce channels plus an all-high flag for the AND-gate stage.
module debounce_3ch
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic in_1,
  input  logic in_2,
  input  logic in_3,
  output logic out_1,
  output logic out_2,
  output logic out_3,
  output logic rise_1,
  output logic rise_2,
  output logic rise_3,
  output logic all_high
);

  if ((STABLE_CNT < 2) || (64'(STABLE_CNT) > (64'd1 << CNT_W))) begin : g_bad_param
    $error("debounce_3ch: STABLE_CNT must be in 2 .. 2**CNT_W");
  end

  debounce_ch #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) u_ch1 (
    .clk (clk), .rst (rst), .in (in_1), .out (out_1), .rise (rise_1)
  );

  debounce_ch #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) u_ch2 (
    .clk (clk), .rst (rst), .in (in_2), .out (out_2), .rise (rise_2)
  );

  debounce_ch #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) u_ch3 (
    .clk (clk), .rst (rst), .in (in_3), .out (out_3), .rise (rise_3)
  );

  // Built only from registered levels, so it is glitch-free.
  assign all_high = out_1 & out_2 & out_3;

endmodule

// File: tb/tb_debounce_3ch.sv
// Directed bench for debounce_3ch at default parameters: vector table plus corner sequences.
module tb_debounce_3ch;

  logic clk = 1'b0;
  logic rst;
  logic in_1, in_2, in_3;
  logic out_1, out_2, out_3;
  logic rise_1, rise_2, rise_3;
  logic all_high;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [2:0] prev_out = 3'b000;
  int unsigned rise_cnt [3] = '{0, 0, 0};

  typedef struct {
    logic        rst;
    logic [2:0]  in;      // {in_3, in_2, in_1}
    int unsigned n;       // cycles to hold before checking
    logic [2:0]  exp_out;
    logic [2:0]  exp_rise;
    logic        exp_all;
  } vec_t;

  vec_t vecs[$];

  debounce_3ch dut (
    .clk      (clk),
    .rst      (rst),
    .in_1     (in_1),
    .in_2     (in_2),
    .in_3     (in_3),
    .out_1    (out_1),
    .out_2    (out_2),
    .out_3    (out_3),
    .rise_1   (rise_1),
    .rise_2   (rise_2),
    .rise_3   (rise_3),
    .all_high (all_high)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample just after the edge, and check per-cycle invariants.
  task automatic step();
    logic [2:0] o;
    logic [2:0] r;
    @(posedge clk);
    #1;
    o = {out_3, out_2, out_1};
    r = {rise_3, rise_2, rise_1};
    checks++;
    if (r !== (o & ~prev_out)) begin
      failures++;
      $display("FAIL rise_pulse t=%0t rise=%b required=%b", $time, r, o & ~prev_out);
    end
    checks++;
    if (all_high !== (o[0] & o[1] & o[2])) begin
      failures++;
      $display("FAIL all_high_track t=%0t all_high=%b required=%b", $time, all_high, &o);
    end
    for (int c = 0; c < 3; c++) if (r[c] === 1'b1) rise_cnt[c]++;
    prev_out = o;
  endtask

  task automatic add(input logic r, input logic [2:0] i, input int unsigned n,
                     input logic [2:0] eo, input logic [2:0] er, input logic ea);
    vec_t v;
    v.rst = r; v.in = i; v.n = n; v.exp_out = eo; v.exp_rise = er; v.exp_all = ea;
    vecs.push_back(v);
  endtask

  initial begin
    rst  = 1'b1;
    in_1 = 1'b0;
    in_2 = 1'b0;
    in_3 = 1'b0;

    // Reset held 3 cycles with toggling inputs, then 2 quiet cycles after release
    add(1'b1, 3'b101, 1,  3'b000, 3'b000, 1'b0);
    add(1'b1, 3'b010, 1,  3'b000, 3'b000, 1'b0);
    add(1'b1, 3'b111, 1,  3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b000, 1,  3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b000, 1,  3'b000, 3'b000, 1'b0);
    // Clean rise on channel 1: output follows after edge 12
    add(1'b0, 3'b001, 11, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b001, 1,  3'b001, 3'b001, 1'b0);
    add(1'b0, 3'b001, 1,  3'b001, 3'b000, 1'b0);
    // Channel 2: 9-cycle pulse rejected
    add(1'b0, 3'b011, 9,  3'b001, 3'b000, 1'b0);
    add(1'b0, 3'b001, 6,  3'b001, 3'b000, 1'b0);
    // Channel 2: 10-cycle pulse accepted, then falls 12 edges after the low level
    add(1'b0, 3'b011, 10, 3'b001, 3'b000, 1'b0);
    add(1'b0, 3'b001, 2,  3'b011, 3'b010, 1'b0);
    add(1'b0, 3'b001, 9,  3'b011, 3'b000, 1'b0);
    add(1'b0, 3'b001, 1,  3'b001, 3'b000, 1'b0);
    // Channel 3 bounce 1,0,1,1,0 then steady 1
    add(1'b0, 3'b101, 1,  3'b001, 3'b000, 1'b0);
    add(1'b0, 3'b001, 1,  3'b001, 3'b000, 1'b0);
    add(1'b0, 3'b101, 2,  3'b001, 3'b000, 1'b0);
    add(1'b0, 3'b001, 1,  3'b001, 3'b000, 1'b0);
    add(1'b0, 3'b101, 11, 3'b001, 3'b000, 1'b0);
    add(1'b0, 3'b101, 1,  3'b101, 3'b100, 1'b0);
    // Drop everything, then all three rise together
    add(1'b0, 3'b000, 11, 3'b101, 3'b000, 1'b0);
    add(1'b0, 3'b000, 1,  3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 11, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 1,  3'b111, 3'b111, 1'b1);
    add(1'b0, 3'b111, 1,  3'b111, 3'b000, 1'b1);
    add(1'b0, 3'b111, 3,  3'b111, 3'b000, 1'b1);
    // Fall all, then reset while channel 1 counter is at 7
    add(1'b0, 3'b000, 11, 3'b111, 3'b000, 1'b1);
    add(1'b0, 3'b000, 1,  3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b001, 9,  3'b000, 3'b000, 1'b0);
    add(1'b1, 3'b001, 2,  3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b001, 11, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b001, 1,  3'b001, 3'b001, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      {in_3, in_2, in_1} = vecs[i].in;
      repeat (vecs[i].n) step();
      checks++;
      if ({out_3, out_2, out_1} !== vecs[i].exp_out ||
          {rise_3, rise_2, rise_1} !== vecs[i].exp_rise ||
          all_high !== vecs[i].exp_all) begin
        failures++;
        $display("FAIL vec%0d out=%b rise=%b all=%b required out=%b rise=%b all=%b",
                 i, {out_3, out_2, out_1}, {rise_3, rise_2, rise_1}, all_high,
                 vecs[i].exp_out, vecs[i].exp_rise, vecs[i].exp_all);
      end
    end

    // A 9-cycle low glitch on channel 1 must not disturb its high level
    {in_3, in_2, in_1} = 3'b000;
    repeat (9) step();
    {in_3, in_2, in_1} = 3'b001;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if (out_1 !== 1'b1) begin
        failures++;
        $display("FAIL low_glitch cycle=%0d out_1=%b required=1", k, out_1);
      end
    end

    // Exactly one rise pulse per accepted rising edge
    checks++;
    if (rise_cnt[0] != 3) begin
      failures++;
      $display("FAIL rise_count_1 got=%0d required=3", rise_cnt[0]);
    end
    checks++;
    if (rise_cnt[1] != 2) begin
      failures++;
      $display("FAIL rise_count_2 got=%0d required=2", rise_cnt[1]);
    end
    checks++;
    if (rise_cnt[2] != 2) begin
      failures++;
      $display("FAIL rise_count_3 got=%0d required=2", rise_cnt[2]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
